// File: rtl/nonrestoring_divider.sv
// Sequential unsigned radix-2 non-restoring divider.
// Two-cycle operand load, one quotient bit per cycle, final restore.
module nonrestoring_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_DVD,
        S_LD_DVR,
        S_ITER,
        S_CORRECT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [WIDTH:0]   a_shift;
    logic [WIDTH:0]   a_step;

    // One non-restoring step: shift {A,Q}, then add or subtract M by sign of A
    always_comb begin
        a_shift = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
        if (a_q[WIDTH]) begin
            a_step = a_shift + {1'b0, m_q};
        end else begin
            a_step = a_shift - {1'b0, m_q};
        end
    end

    // Controller next state and datapath next values
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LD_DVD;
                    dbz_d   = 1'b0;
                end
            end
            S_LD_DVD: begin
                q_d     = data_in;
                state_d = S_LD_DVR;
            end
            S_LD_DVR: begin
                m_d   = data_in;
                a_d   = '0;
                cnt_d = CW'(WIDTH);
                if (data_in == '0) begin
                    q_d     = '1;
                    a_d     = {1'b0, q_q};
                    dbz_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                a_d   = a_step;
                q_d   = {q_q[WIDTH-2:0], ~a_step[WIDTH]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_CORRECT;
                end
            end
            S_CORRECT: begin
                if (a_q[WIDTH]) begin
                    a_d = a_q + {1'b0, m_q};
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    // State, datapath and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign quotient    = q_q;
    assign remainder   = a_q[WIDTH-1:0];
    assign done        = done_q;
    assign busy        = busy_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Directed bench for nonrestoring_divider (WIDTH=16).
// Vector table plus hand sequences for held start and mid-run reset.
module tb_nonrestoring_divider;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] data_in;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         done;
    logic         busy;
    logic         div_by_zero;

    int n_chk = 0;
    int n_bad = 0;

    nonrestoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .data_in     (data_in),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvr;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           edges;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Run one division; returns the edge number after which done was seen.
    task automatic do_op(input logic [W-1:0] dvd, input logic [W-1:0] dvr,
                         input bit hold, output int edges, output bit busy_ok);
        int n;
        busy_ok = 1'b1;
        @(negedge clk);
        start   = 1'b1;
        data_in = dvd;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        if (!busy) busy_ok = 1'b0;
        @(posedge clk);
        @(negedge clk);
        data_in = dvr;
        @(posedge clk);
        n = 2;
        @(negedge clk);
        data_in = W'($urandom);
        while (!done && n < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            n++;
            @(negedge clk);
            data_in = W'($urandom);
        end
        edges = n;
    endtask

    initial begin
        int  e;
        bit  bok;
        logic [W-1:0] hq, hr;

        vecs[0] = '{16'h8006, 16'h000D, 16'h09D9, 16'h0001, 1'b0, 19};
        vecs[1] = '{16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 19};
        vecs[2] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 19};
        vecs[3] = '{16'd5,    16'd9,    16'd0,    16'd5,    1'b0, 19};
        vecs[4] = '{16'd1234, 16'd0,    16'hFFFF, 16'd1234, 1'b1, 2};
        vecs[5] = '{16'd10,   16'd3,    16'd3,    16'd1,    1'b0, 19};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 16'd1,    16'd0,    1'b0, 19};
        vecs[7] = '{16'd7,    16'hFFFF, 16'd0,    16'd7,    1'b0, 19};
        vecs[8] = '{16'd0,    16'd5,    16'd0,    16'd0,    1'b0, 19};

        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        #12;
        chk("rst_quotient", 32'(quotient), 32'h0);
        chk("rst_remainder", 32'(remainder), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_dbz", 32'(div_by_zero), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].dvd, vecs[i].dvr, 1'b0, e, bok);
            chk($sformatf("v%0d_edges", i), 32'(e), 32'(vecs[i].edges));
            chk($sformatf("v%0d_quotient", i), 32'(quotient), 32'(vecs[i].q));
            chk($sformatf("v%0d_remainder", i), 32'(remainder),
                32'(vecs[i].r));
            chk($sformatf("v%0d_dbz", i), 32'(div_by_zero),
                32'(vecs[i].dbz));
            chk($sformatf("v%0d_busy_run", i), 32'(bok), 32'h1);
            chk($sformatf("v%0d_busy_done", i), 32'(busy), 32'h0);
            // start already low: one edge returns to IDLE, outputs held
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_idle_done", i), 32'(done), 32'h0);
            chk($sformatf("v%0d_idle_q", i), 32'(quotient), 32'(vecs[i].q));
        end

        // start held through the result: no retrigger, outputs frozen
        do_op(16'd100, 16'd7, 1'b1, e, bok);
        chk("hold_edges", 32'(e), 32'd19);
        hq = quotient;
        hr = remainder;
        chk("hold_q", 32'(hq), 32'd14);
        chk("hold_r", 32'(hr), 32'd2);
        for (int k = 0; k < 5; k++) begin
            data_in = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("hold_done_%0d", k), 32'(done), 32'h1);
            chk($sformatf("hold_busy_%0d", k), 32'(busy), 32'h0);
            chk($sformatf("hold_qq_%0d", k), 32'(quotient), 32'd14);
            chk($sformatf("hold_rr_%0d", k), 32'(remainder), 32'd2);
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("hold_release", 32'(done), 32'h0);

        // reset asserted in the middle of ITER
        start   = 1'b1;
        data_in = 16'h8006;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        data_in = 16'h000D;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_q", 32'(quotient), 32'h0);
        chk("mid_rst_r", 32'(remainder), 32'h0);
        chk("mid_rst_done", 32'(done), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_dbz", 32'(div_by_zero), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h8006, 16'h000D, 1'b0, e, bok);
        chk("post_rst_edges", 32'(e), 32'd19);
        chk("post_rst_q", 32'(quotient), 32'h09D9);
        chk("post_rst_r", 32'(remainder), 32'h0001);
        chk("post_rst_dbz", 32'(div_by_zero), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/nonrestoring_divider.md
# nonrestoring_divider

Sequential unsigned integer divider, the inverse companion to the Booth multiplier in the same arithmetic library. It uses the same operand-loading protocol: a `start` request followed by two operands presented on a shared `data_in` bus in consecutive cycles. It computes quotient and remainder with a radix-2 non-restoring algorithm, one quotient bit per cycle. It is a controller FSM plus a shift/add-subtract datapath in a single module.

## Interface
- `WIDTH`, default 16: operand, quotient and remainder width. Legal range is ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; level-sampled in IDLE.
- `data_in`  in  WIDTH  dividend in the first load cycle, divisor in the second.
- `quotient`  out  WIDTH  registered quotient; valid while `done`=1.
- `remainder`  out  WIDTH  registered remainder; valid while `done`=1.
- `done`  out  1  result valid; held high in DONE.
- `busy`  out  1  high in every state except IDLE and DONE.
- `div_by_zero`  out  1  divisor was 0; valid while `done`=1.

## Operation
- Datapath registers:
  - A: WIDTH+1 bits, signed partial remainder.
  - Q: WIDTH bits, dividend that becomes the quotient.
  - M: WIDTH bits, divisor.
  - cnt: ceil(log2(WIDTH+1)) bits.
- `quotient` = Q. `remainder` = A[WIDTH-1:0].
- States and transitions:
  - IDLE: `start`=1 → LD_DVD; otherwise stay in IDLE.
  - LD_DVD: Q ← `data_in`; go to LD_DVR.
  - LD_DVR: M ← `data_in`, A ← 0, cnt ← WIDTH.
    - If `data_in`=0: Q ← all ones, A ← {0, Q}, `div_by_zero` ← 1, go to DONE.
    - Otherwise: go to ITER.
  - ITER, one step per cycle:
    - Shift {A,Q} left by 1.
    - If A[WIDTH] was 0 before the step, A ← shifted A − {0,M}; otherwise A ← shifted A + {0,M}.
    - Q[0] ← ~A_new[WIDTH].
    - cnt ← cnt−1. When cnt reaches 1 in this cycle, go to CORRECT.
  - CORRECT: if A[WIDTH]=1 then A ← A + {0,M}; go to DONE.
  - DONE: `done`=1. Go to IDLE when `start`=0; stay in DONE while `start`=1, so a held `start` never retriggers.
- `div_by_zero` is cleared when the FSM enters LD_DVD.
- `start` outside IDLE is ignored. Operands are captured only in LD_DVD and LD_DVR, so `data_in` is don't-care in all other states.
- All arithmetic is unsigned on the WIDTH-bit inputs. A is one bit wider to hold the sign, and no overflow is possible. Results always satisfy dividend = quotient·divisor + remainder, with remainder < divisor.

## Timing
- Reset (asynchronous, active-low): state = IDLE; A, Q, M and cnt = 0; `quotient`=0, `remainder`=0, `done`=0, `busy`=0, `div_by_zero`=0.
- Reset mid-operation aborts immediately to these values. There is no partial result.
- Edge numbering: edge 0 is the edge that samples `start`=1 in IDLE.
  - The dividend must be valid at edge 1; the divisor at edge 2.
  - ITER runs over edges 3..WIDTH+2. CORRECT is at edge WIDTH+3.
  - `done` rises after edge WIDTH+3, i.e. edge 19 for WIDTH=16.
- Divide-by-zero: `done` and `div_by_zero` rise after edge 2.
- `busy` is high after edges 0 through WIDTH+2 and low in DONE.
- Outputs hold their values in DONE and through the following IDLE, until the next LD_DVD overwrites Q.
- Back-to-back operation: the minimum gap is one IDLE cycle after `start` is dropped in DONE.

## Test plan
- Dividend 0x8006, divisor 0x000D → `quotient`=0x09D9, `remainder`=0x0001, `done` rises after edge 19, `div_by_zero`=0.
- 100 / 7 → `quotient`=14, `remainder`=2. Then drop `start`, wait one IDLE cycle, request 0xFFFF / 0x0001 → `quotient`=0xFFFF, `remainder`=0.
- 5 / 9 (dividend < divisor) → `quotient`=0, `remainder`=5. The CORRECT state must apply the restore.
- 1234 / 0 → `done`=1 and `div_by_zero`=1 after edge 2, `quotient`=0xFFFF, `remainder`=1234. A following 10/3 → `div_by_zero`=0, `quotient`=3, `remainder`=1.
- `start` held high through the result → `done` stays high and no new load occurs. Toggling `data_in` in DONE → outputs unchanged.
- Assert `rst_n`=0 during ITER (edge 8) → all outputs 0 immediately. After release, a fresh 0x8006 / 0x000D completes correctly.
